multdiv_arbiter: RTL and testbench
==================================

# multdiv_arbiter

Sequencer that shares the single iterative multiply/divide unit between the top and bottom issue lanes of the dual-issue pipeline. It sits beside the execute stage: it takes the isMult/isDiv flags and forwarded operands from decode, serialises requests (top lane first), pulses the unit's start controls, and holds the whole pipeline until the result returns. It then presents each result, tagged with lane and destination register, for writeback.

## Interface
Parameters:
- TIMEOUT, 64, maximum cycles spent in WAIT before a forced exception result; legal range 2..127.

Ports:
- clock  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous squash from branch-mispredict recovery.
- isMult_top, isDiv_top  in  1  top-lane request flags, mutually exclusive.
- opA_top, opB_top  in  32  top-lane forwarded operands.
- rd_top  in  5  top-lane destination register.
- isMult_bot, isDiv_bot, opA_bot, opB_bot, rd_bot  in  1/1/32/32/5  bottom-lane equivalents.
- ctrl_MULT, ctrl_DIV  out  1  one-cycle start pulses to the unit.
- data_operandA, data_operandB  out  32  operands to the unit, held stable from ISSUE through WAIT.
- data_result  in  32  unit result.
- data_exception  in  1  unit exception; divide-by-zero or overflow.
- data_resultRDY  in  1  unit result-valid strobe.
- stall_pipe  out  1  freezes both lanes of F/D/X; combinational.
- result_valid  out  1  one-cycle writeback strobe.
- result  out  32  result; 0 on timeout.
- result_rd  out  5  destination register of the result.
- result_lane  out  1  0 = top, 1 = bottom.
- result_exception  out  1  unit exception or timeout.

## Operation
- req_top = isMult_top|isDiv_top; req_bot likewise.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE, on req_top|req_bot:
  - Latch the active op: top if req_top, else bot. The op is kind (mult/div), operands, rd and lane.
  - If both lanes request, also latch bot into the pending register and set pend_bot.
  - Go to ISSUE.
  - data_resultRDY is ignored in IDLE.
- ISSUE:
  - Assert exactly one of ctrl_MULT/ctrl_DIV for one cycle, matching the active kind.
  - Clear the 7-bit counter.
  - Go to WAIT.
- WAIT, each cycle:
  - If data_resultRDY: capture data_result and data_exception, go to WB.
  - Else if counter == TIMEOUT-1: capture result=0 and exception=1, go to WB.
  - Else increment the counter.
- WB:
  - Assert result_valid. result, result_rd, result_lane and result_exception come from the captured registers.
  - If pend_bot: move the pending op to active, clear pend_bot, go to ISSUE.
  - Else go to IDLE.
- stall_pipe = (IDLE & (req_top|req_bot)) | ISSUE | WAIT | (WB & pend_bot).
  - The stall drops in the final WB cycle, so the held instruction advances on that edge.
  - The stall drop must not cause a second request to be accepted from the same instruction.
- flush, synchronous, any state:
  - Next state is IDLE; pend_bot is cleared.
  - result_valid is 0 in the flush cycle.
  - Any result still in flight from the unit is discarded; the next ISSUE pulse restarts the unit.
  - flush has priority over every other transition.
- Reset values: state IDLE; ctrl_MULT, ctrl_DIV, result_valid, result_exception = 0; result, result_rd, result_lane = 0; data_operandA/B = 0; pend_bot = 0; counter = 0.

## Timing
- Request seen in IDLE at cycle N → ctrl pulse at N+1 → WAIT from N+2.
- data_resultRDY at cycle M → result_valid at M+1.
- Minimum single-op occupancy is 4 cycles (IDLE capture, ISSUE, WAIT, WB), with resultRDY in the first WAIT cycle.
- Dual request: the top op completes with WB, then ISSUE for bot follows immediately. The two result_valid strobes are separated by at least 3 cycles; stall_pipe stays continuously high between them.
- Timeout: WB occurs exactly TIMEOUT cycles after the first WAIT cycle when resultRDY never arrives.
- data_resultRDY coinciding with the timeout cycle: the real result wins.
- Reset asserted mid-operation: all outputs return to reset values immediately. No ctrl pulse is issued after deassertion until a new request arrives.

## Structure
- Shared package (processor_pkg): state encoding enum (IDLE/ISSUE/WAIT/WB), the lane constants LANE_TOP=0 and LANE_BOT=1, and the op record type (kind, opA, opB, rd, lane).
- Single module. The active and pending op registers are instances of the packaged record.
- No sub-module.

## Test plan
- Top mult alone: opA=6, opB=7, rd=5, resultRDY 10 cycles after ctrl_MULT with result 42 → one ctrl_MULT pulse; result_valid with result=42, rd=5, lane=0, exception=0; stall high from the request cycle up to the WB cycle.
- Simultaneous top div 100/5 (rd=3) and bot mult 3*4 (rd=9) → first WB gives 20/rd3/lane0, second gives 12/rd9/lane1; exactly two ctrl pulses, DIV then MULT; stall never drops between them.
- Div by zero: unit returns exception=1 → result_exception=1, lane and rd correct, arbiter returns to IDLE.
- Timeout with TIMEOUT=8 and resultRDY never asserted → WB 8 cycles after WAIT entry with result=0, exception=1.
- Flush during WAIT, with a late resultRDY two cycles later → no result_valid, stall low the cycle after the flush, the late strobe is ignored; the next request issues normally.
- Reset asserted during WAIT of a dual request → immediate return to IDLE, pend_bot=0, no further ctrl pulses.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared types for the multiply/divide arbiter: FSM encoding, lane constants
// and the operation record held in the active and pending slots.
package processor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } stateT;

  typedef enum logic {
    KIND_MULT = 1'b0,
    KIND_DIV  = 1'b1
  } opKindT;

  localparam logic LANE_TOP = 1'b0;
  localparam logic LANE_BOT = 1'b1;
  localparam int   COUNT_W  = 7;

  typedef struct packed {
    opKindT      kind;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  rd;
    logic        lane;
  } opT;

endpackage

// File: rtl/multdiv_arbiter.sv
// Serialises top/bottom lane mult/div requests onto the single iterative unit,
// stalls the pipeline while busy and presents each tagged result for writeback.
module multdiv_arbiter
  import processor_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        isMult_top,
  input  logic        isDiv_top,
  input  logic [31:0] opA_top,
  input  logic [31:0] opB_top,
  input  logic [4:0]  rd_top,
  input  logic        isMult_bot,
  input  logic        isDiv_bot,
  input  logic [31:0] opA_bot,
  input  logic [31:0] opB_bot,
  input  logic [4:0]  rd_bot,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall_pipe,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        result_lane,
  output logic        result_exception
);

  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(TIMEOUT - 1);

  stateT              stateReg, stateNext;
  opT                 activeReg, activeNext;
  opT                 pendReg, pendNext;
  logic               pendBotReg, pendBotNext;
  logic [COUNT_W-1:0] countReg, countNext;
  logic [31:0]        resultReg, resultNext;
  logic [4:0]         resultRdReg, resultRdNext;
  logic               resultLaneReg, resultLaneNext;
  logic               resultExcReg, resultExcNext;

  logic reqTop, reqBot;
  opT   topOp, botOp;

  assign reqTop = isMult_top | isDiv_top;
  assign reqBot = isMult_bot | isDiv_bot;

  always_comb begin
    topOp.kind = isDiv_top ? KIND_DIV : KIND_MULT;
    topOp.opA  = opA_top;
    topOp.opB  = opB_top;
    topOp.rd   = rd_top;
    topOp.lane = LANE_TOP;
    botOp.kind = isDiv_bot ? KIND_DIV : KIND_MULT;
    botOp.opA  = opA_bot;
    botOp.opB  = opB_bot;
    botOp.rd   = rd_bot;
    botOp.lane = LANE_BOT;
  end

  always_comb begin
    stateNext      = stateReg;
    activeNext     = activeReg;
    pendNext       = pendReg;
    pendBotNext    = pendBotReg;
    countNext      = countReg;
    resultNext     = resultReg;
    resultRdNext   = resultRdReg;
    resultLaneNext = resultLaneReg;
    resultExcNext  = resultExcReg;
    if (flush) begin
      // Squash: anything the unit still returns is simply never captured.
      stateNext   = IDLE;
      pendBotNext = 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (reqTop || reqBot) begin
            activeNext = reqTop ? topOp : botOp;
            if (reqTop && reqBot) begin
              pendNext    = botOp;
              pendBotNext = 1'b1;
            end
            stateNext = ISSUE;
          end
        end
        ISSUE: begin
          countNext = '0;
          stateNext = WAIT;
        end
        WAIT: begin
          // A result arriving on the timeout cycle takes precedence.
          if (data_resultRDY) begin
            resultNext     = data_result;
            resultExcNext  = data_exception;
            resultRdNext   = activeReg.rd;
            resultLaneNext = activeReg.lane;
            stateNext      = WB;
          end else if (countReg == COUNT_LAST) begin
            resultNext     = '0;
            resultExcNext  = 1'b1;
            resultRdNext   = activeReg.rd;
            resultLaneNext = activeReg.lane;
            stateNext      = WB;
          end else begin
            countNext = countReg + 1'b1;
          end
        end
        WB: begin
          if (pendBotReg) begin
            activeNext  = pendReg;
            pendBotNext = 1'b0;
            stateNext   = ISSUE;
          end else begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg      <= IDLE;
      activeReg     <= '0;
      pendReg       <= '0;
      pendBotReg    <= 1'b0;
      countReg      <= '0;
      resultReg     <= '0;
      resultRdReg   <= '0;
      resultLaneReg <= 1'b0;
      resultExcReg  <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      activeReg     <= activeNext;
      pendReg       <= pendNext;
      pendBotReg    <= pendBotNext;
      countReg      <= countNext;
      resultReg     <= resultNext;
      resultRdReg   <= resultRdNext;
      resultLaneReg <= resultLaneNext;
      resultExcReg  <= resultExcNext;
    end
  end

  // Start pulses are suppressed on a flush so a squashed op never reaches the unit.
  assign ctrl_MULT = (stateReg == ISSUE) && (activeReg.kind == KIND_MULT) && !flush;
  assign ctrl_DIV  = (stateReg == ISSUE) && (activeReg.kind == KIND_DIV) && !flush;

  assign data_operandA = activeReg.opA;
  assign data_operandB = activeReg.opB;

  assign stall_pipe = ((stateReg == IDLE) && (reqTop || reqBot)) ||
                      (stateReg == ISSUE) || (stateReg == WAIT) ||
                      ((stateReg == WB) && pendBotReg);

  assign result_valid     = (stateReg == WB) && !flush;
  assign result           = resultReg;
  assign result_rd        = resultRdReg;
  assign result_lane      = resultLaneReg;
  assign result_exception = resultExcReg;

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Scoreboard bench for multdiv_arbiter: a default-timeout instance carries the
// main traffic, a TIMEOUT=8 instance on the same inputs covers the timeout path.
module tb_multdiv_arbiter;

  logic        clock, reset, flush;
  logic        isMult_top, isDiv_top, isMult_bot, isDiv_bot;
  logic [31:0] opA_top, opB_top, opA_bot, opB_bot;
  logic [4:0]  rd_top, rd_bot;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  logic        ctrlMult, ctrlDiv, stall, resValid, resLane, resExc;
  logic [31:0] operandA, operandB, resData;
  logic [4:0]  resRd;
  logic        toCtrlMult, toCtrlDiv, toStall, toValid, toLane, toExc;
  logic [31:0] toOperandA, toOperandB, toResult;
  logic [4:0]  toRd;

  multdiv_arbiter dut (
    .clock(clock), .reset(reset), .flush(flush),
    .isMult_top(isMult_top), .isDiv_top(isDiv_top), .opA_top(opA_top), .opB_top(opB_top), .rd_top(rd_top),
    .isMult_bot(isMult_bot), .isDiv_bot(isDiv_bot), .opA_bot(opA_bot), .opB_bot(opB_bot), .rd_bot(rd_bot),
    .ctrl_MULT(ctrlMult), .ctrl_DIV(ctrlDiv), .data_operandA(operandA), .data_operandB(operandB),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .stall_pipe(stall), .result_valid(resValid), .result(resData), .result_rd(resRd),
    .result_lane(resLane), .result_exception(resExc)
  );

  multdiv_arbiter #(.TIMEOUT(8)) dutTo (
    .clock(clock), .reset(reset), .flush(flush),
    .isMult_top(isMult_top), .isDiv_top(isDiv_top), .opA_top(opA_top), .opB_top(opB_top), .rd_top(rd_top),
    .isMult_bot(isMult_bot), .isDiv_bot(isDiv_bot), .opA_bot(opA_bot), .opB_bot(opB_bot), .rd_bot(rd_bot),
    .ctrl_MULT(toCtrlMult), .ctrl_DIV(toCtrlDiv), .data_operandA(toOperandA), .data_operandB(toOperandB),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .stall_pipe(toStall), .result_valid(toValid), .result(toResult), .result_rd(toRd),
    .result_lane(toLane), .result_exception(toExc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        lane;
    logic        exc;
  } expT;

  expT  resQ[$];
  logic ctrlQ[$];  // 1 = DIV expected, 0 = MULT expected
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic expT mkExp(input logic [31:0] res, input logic [4:0] rd, input logic lane,
                                input logic exc);
    expT e;
    e.res  = res;
    e.rd   = rd;
    e.lane = lane;
    e.exc  = exc;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearReq();
    isMult_top = 1'b0; isDiv_top = 1'b0; isMult_bot = 1'b0; isDiv_bot = 1'b0;
  endtask

  // Scoreboard: every start pulse and writeback of the main instance is popped and compared.
  always @(negedge clock) begin : monitor
    expT  e;
    logic k;
    if (!reset) begin
      if (ctrlMult || ctrlDiv) begin
        check("ctrl_expected", 32'(ctrlQ.size() != 0), 1);
        if (ctrlQ.size() != 0) begin
          k = ctrlQ.pop_front();
          check("ctrl_kind", {30'd0, ctrlDiv, ctrlMult}, k ? 32'd2 : 32'd1);
          $display("ctrl pulse %s opA=%0d opB=%0d", ctrlDiv ? "DIV" : "MULT", operandA, operandB);
        end
      end
      if (resValid) begin
        check("wb_expected", 32'(resQ.size() != 0), 1);
        if (resQ.size() != 0) begin
          e = resQ.pop_front();
          check("wb_result", resData, e.res);
          check("wb_rd", 32'(resRd), 32'(e.rd));
          check("wb_lane", 32'(resLane), 32'(e.lane));
          check("wb_exc", 32'(resExc), 32'(e.exc));
          $display("writeback lane=%0d rd=%0d result=%0d exc=%0d", resLane, resRd, resData, resExc);
        end
      end
    end
  end

  // Entered in the ISSUE cycle; leaves in the WB cycle.
  task automatic serveOp(input string tag, input logic isDiv, input logic [31:0] a, input logic [31:0] b,
                         input int delay, input logic [31:0] res, input logic exc, input logic wbStall);
    check({tag, "_ctrl"}, {30'd0, ctrlDiv, ctrlMult}, isDiv ? 32'd2 : 32'd1);
    check({tag, "_opA"}, operandA, a);
    check({tag, "_opB"}, operandB, b);
    check({tag, "_stall_issue"}, 32'(stall), 1);
    for (int i = 0; i < delay; i++) begin
      step();
      #1 check({tag, "_stall_wait"}, 32'(stall), 1);
    end
    step();
    data_resultRDY = 1'b1; data_result = res; data_exception = exc;
    #1 check({tag, "_stall_rdy"}, 32'(stall), 1);
    check({tag, "_valid_early"}, 32'(resValid), 0);
    step();
    data_resultRDY = 1'b0; data_result = '0; data_exception = 1'b0;
    #1 check({tag, "_stall_wb"}, 32'(stall), 32'(wbStall));
    check({tag, "_valid_wb"}, 32'(resValid), 1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    clearReq();
    opA_top = '0; opB_top = '0; rd_top = '0; opA_bot = '0; opB_bot = '0; rd_bot = '0;
    data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
    #2;
    check("rst_stall", 32'(stall), 0);
    check("rst_ctrl", {30'd0, ctrlDiv, ctrlMult}, 0);
    check("rst_valid", 32'(resValid), 0);
    check("rst_result", resData, 0);
    check("rst_opA", operandA, 0);
    step(); step();
    reset = 1'b0;
    step();

    // Top-lane multiply alone, result 10 cycles after the start pulse.
    isMult_top = 1'b1; opA_top = 6; opB_top = 7; rd_top = 5;
    resQ.push_back(mkExp(42, 5, 1'b0, 1'b0)); ctrlQ.push_back(1'b0);
    #1 check("t1_stall_req", 32'(stall), 1);
    step();
    serveOp("t1", 1'b0, 6, 7, 9, 42, 1'b0, 1'b0);
    step(); clearReq();
    #1 check("t1_idle_stall", 32'(stall), 0);
    check("t1_no_reissue", {30'd0, ctrlDiv, ctrlMult}, 0);

    // Simultaneous top divide and bottom multiply.
    isDiv_top = 1'b1; opA_top = 100; opB_top = 5; rd_top = 3;
    isMult_bot = 1'b1; opA_bot = 3; opB_bot = 4; rd_bot = 9;
    resQ.push_back(mkExp(20, 3, 1'b0, 1'b0)); resQ.push_back(mkExp(12, 9, 1'b1, 1'b0));
    ctrlQ.push_back(1'b1); ctrlQ.push_back(1'b0);
    #1 check("t2_stall_req", 32'(stall), 1);
    step();
    serveOp("t2a", 1'b1, 100, 5, 0, 20, 1'b0, 1'b1);
    step();
    serveOp("t2b", 1'b0, 3, 4, 2, 12, 1'b0, 1'b0);
    step(); clearReq();
    #1 check("t2_idle_stall", 32'(stall), 0);

    // Bottom-lane divide by zero.
    isDiv_bot = 1'b1; opA_bot = 9; opB_bot = 0; rd_bot = 17;
    resQ.push_back(mkExp(0, 17, 1'b1, 1'b1)); ctrlQ.push_back(1'b1);
    step();
    serveOp("t3", 1'b1, 9, 0, 3, 0, 1'b1, 1'b0);
    step(); clearReq();
    step();
    #1 check("t3_idle_stall", 32'(stall), 0);
    check("t3_idle_ctrl", {30'd0, ctrlDiv, ctrlMult}, 0);

    // Timeout on the TIMEOUT=8 instance; the main instance is flushed afterwards.
    isMult_top = 1'b1; opA_top = 2; opB_top = 3; rd_top = 2;
    ctrlQ.push_back(1'b0);
    step();
    #1 check("t4_ctrl", 32'(toCtrlMult), 1);
    step();
    for (int k = 1; k < 8; k++) begin
      step();
      #1 check("t4_pending_valid", 32'(toValid), 0);
      check("t4_pending_stall", 32'(toStall), 1);
    end
    step();
    #1 check("t4_to_valid", 32'(toValid), 1);
    check("t4_to_result", toResult, 0);
    check("t4_to_exc", 32'(toExc), 1);
    check("t4_to_rd", 32'(toRd), 2);
    check("t4_to_lane", 32'(toLane), 0);
    flush = 1'b1; clearReq();
    step(); flush = 1'b0;
    #1 check("t4_flush_stall", 32'(stall), 0);

    // Flush during WAIT with a late result strobe, then a normal request.
    isMult_top = 1'b1; opA_top = 11; opB_top = 13; rd_top = 6;
    ctrlQ.push_back(1'b0);
    step();
    #1 check("t5_ctrl", 32'(ctrlMult), 1);
    step(); step();
    flush = 1'b1; clearReq();
    #1 check("t5_flush_valid", 32'(resValid), 0);
    step(); flush = 1'b0;
    #1 check("t5_after_flush_stall", 32'(stall), 0);
    step();
    data_resultRDY = 1'b1; data_result = 143;
    #1 check("t5_late_stall", 32'(stall), 0);
    step();
    data_resultRDY = 1'b0; data_result = '0;
    #1 check("t5_late_valid", 32'(resValid), 0);
    isDiv_top = 1'b1; opA_top = 50; opB_top = 7; rd_top = 4;
    resQ.push_back(mkExp(7, 4, 1'b0, 1'b0)); ctrlQ.push_back(1'b1);
    #1 check("t5b_stall_req", 32'(stall), 1);
    step();
    serveOp("t5b", 1'b1, 50, 7, 1, 7, 1'b0, 1'b0);
    step(); clearReq();

    // Reset asserted mid-WAIT of a dual request.
    isMult_top = 1'b1; opA_top = 1; opB_top = 2; rd_top = 1;
    isDiv_bot = 1'b1; opA_bot = 8; opB_bot = 2; rd_bot = 8;
    ctrlQ.push_back(1'b0);
    step(); step(); step();
    #2 reset = 1'b1; clearReq();
    #1 check("t6_rst_stall", 32'(stall), 0);
    check("t6_rst_ctrl", {30'd0, ctrlDiv, ctrlMult}, 0);
    check("t6_rst_opA", operandA, 0);
    check("t6_rst_result", resData, 0);
    check("t6_rst_rd", 32'(resRd), 0);
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      data_resultRDY = (k == 2); data_result = 5;
      #1 check("t6_quiet_ctrl", {30'd0, ctrlDiv, ctrlMult}, 0);
      check("t6_quiet_stall", 32'(stall), 0);
      check("t6_quiet_valid", 32'(resValid), 0);
    end
    data_resultRDY = 1'b0; data_result = '0;
    step();

    check("ctrl_queue_drained", 32'(ctrlQ.size()), 0);
    check("result_queue_drained", 32'(resQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
